fp_mul_round_norm: RTL and testbench

- Pipelined post-processing stage directly downstream of the single-precision floating multiplier's significand product.
- Consumes the raw 48-bit significand product, the unadjusted biased exponent sum, the result sign and the operand class flags.
- Normalizes, rounds to nearest-even, and handles special values; produces the IEEE-754 binary32 result with overflow, underflow and exception flags.
- Two register stages with valid/ready flow control, one result per cycle.

---
 rtl/fp_mul_round_norm.sv | 165 ++++++++++++++++
 tb/tb_fp_mul_round_norm.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_round_norm.sv
// binary32 multiplier back end: normalize, round-to-nearest-even, pack.
// Define FMUL_STICKY_FLAGS_EN to add the accumulated flag register.
module fp_mul_round_norm #(
  parameter int XLEN = 32,
  parameter int EXPW = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_sign,
  input  logic [EXPW-1:0] in_exp,
  input  logic [47:0]     in_mant,
  input  logic            in_nan,
  input  logic            in_inf,
  input  logic            in_zero,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            overflow,
  output logic            underflow,
  output logic            exception
`ifdef FMUL_STICKY_FLAGS_EN
  ,
  input  logic            flags_clr,
  output logic [2:0]      sticky_flags
`endif
);

  localparam int EW = EXPW + 1;

  localparam logic signed [EW-1:0] EXP_OVF = EW'(255);
  localparam logic signed [EW-1:0] EXP_UNF = '0;

  typedef struct packed {
    logic                 sign;
    logic signed [EW-1:0] exp;
    logic [22:0]          frac;
    logic                 guard;
    logic                 sticky;
    logic                 nan;
    logic                 inf;
    logic                 zero;
  } norm_t;

  norm_t s1_d;
  norm_t s1_q;

  logic s1_valid;
  logic s2_valid;
  logic s1_load;
  logic s2_load;

  logic [EW-1:0] exp_ext;

  logic                 rnd;
  logic [23:0]          sum;
  logic signed [EW-1:0] exp_r;

  logic [XLEN-1:0] res_d;
  logic            ovf_d;
  logic            unf_d;
  logic            exc_d;

  assign s2_load   = !s2_valid || out_ready;
  assign s1_load   = !s1_valid || s2_load;
  assign in_ready  = s1_load;
  assign out_valid = s2_valid;

  assign exp_ext = {in_exp[EXPW-1], in_exp};

  always_comb begin
    s1_d      = '0;
    s1_d.sign = in_sign;
    s1_d.nan  = in_nan;
    s1_d.inf  = in_inf;
    s1_d.zero = in_zero;
    s1_d.exp  = exp_ext
              + {{(EW-1){1'b0}}, in_mant[47]};
    if (in_mant[47]) begin
      s1_d.frac   = in_mant[46:24];
      s1_d.guard  = in_mant[23];
      s1_d.sticky = |in_mant[22:0];
    end else begin
      s1_d.frac   = in_mant[45:23];
      s1_d.guard  = in_mant[22];
      s1_d.sticky = |in_mant[21:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) s1_q <= s1_d;
    end
  end

  // Fraction overflow from rounding leaves sum[22:0] at zero.
  always_comb begin
    rnd   = s1_q.guard & (s1_q.sticky | s1_q.frac[0]);
    sum   = {1'b0, s1_q.frac} + {23'd0, rnd};
    exp_r = s1_q.exp + {{(EW-1){1'b0}}, sum[23]};
    res_d = '0;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    exc_d = 1'b0;
    if (s1_q.nan || (s1_q.inf && s1_q.zero)) begin
      res_d = 32'h7FC0_0000;
      exc_d = 1'b1;
    end else if (s1_q.inf) begin
      res_d = {s1_q.sign, 8'hFF, 23'h0};
    end else if (s1_q.zero) begin
      res_d = {s1_q.sign, 31'h0};
    end else if (exp_r >= EXP_OVF) begin
      res_d = {s1_q.sign, 8'hFF, 23'h0};
      ovf_d = 1'b1;
    end else if (exp_r <= EXP_UNF) begin
      res_d = {s1_q.sign, 31'h0};
      unf_d = 1'b1;
    end else begin
      res_d = {s1_q.sign, exp_r[7:0], sum[22:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      exception <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        result    <= res_d;
        overflow  <= ovf_d;
        underflow <= unf_d;
        exception <= exc_d;
      end
    end
  end

`ifdef FMUL_STICKY_FLAGS_EN
  logic [2:0] acc_q;
  logic [2:0] cur_flags;

  assign cur_flags    = {exception, underflow, overflow};
  assign sticky_flags = acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (out_valid && out_ready) begin
      acc_q <= flags_clr ? cur_flags
                         : (acc_q | cur_flags);
    end else if (flags_clr) begin
      acc_q <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_fp_mul_round_norm.sv
// Bench for fp_mul_round_norm: scoreboard against an arithmetic model,
// directed test-plan vectors, backpressure and mid-stream reset.
module tb_fp_mul_round_norm;

  typedef struct packed {
    logic        sign;
    logic [9:0]  exp;
    logic [47:0] mant;
    logic        nan;
    logic        inf;
    logic        zero;
  } vec_t;

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    logic        exc;
  } out_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [9:0]  in_exp = '0;
  logic [47:0] in_mant = '0;
  logic        in_nan = 1'b0;
  logic        in_inf = 1'b0;
  logic        in_zero = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;
  logic        exception;
`ifdef FMUL_STICKY_FLAGS_EN
  logic        flags_clr = 1'b0;
  logic [2:0]  sticky_flags;
`endif

  int   errors = 0;
  int   checks = 0;
  int   n_acc = 0;
  out_t exp_q[$];
  out_t got;
  vec_t cv;

  always #5 clk = ~clk;

  fp_mul_round_norm dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .in_nan    (in_nan),
    .in_inf    (in_inf),
    .in_zero   (in_zero),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow),
`ifdef FMUL_STICKY_FLAGS_EN
    .flags_clr    (flags_clr),
    .sticky_flags (sticky_flags),
`endif
    .exception (exception)
  );

  // Value-level model: quotient/remainder against the halfway point.
  function automatic out_t model(vec_t v);
    out_t   o;
    longint m, q, r, half;
    int     sh, e;
    m    = v.mant;
    sh   = v.mant[47] ? 24 : 23;
    e    = int'($signed(v.exp)) + (v.mant[47] ? 1 : 0);
    q    = m >> sh;
    r    = m - (q << sh);
    half = longint'(1) << (sh - 1);
    if (r > half || (r == half && q % 2 == 1)) q = q + 1;
    if (q >= (longint'(1) << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    o = '0;
    if (v.nan || (v.inf && v.zero)) begin
      o.res = 32'h7FC0_0000;
      o.exc = 1'b1;
    end else if (v.inf) begin
      o.res = {v.sign, 8'hFF, 23'h0};
    end else if (v.zero) begin
      o.res = {v.sign, 31'h0};
    end else if (e >= 255) begin
      o.res = {v.sign, 8'hFF, 23'h0};
      o.ovf = 1'b1;
    end else if (e <= 0) begin
      o.res = {v.sign, 31'h0};
      o.unf = 1'b1;
    end else begin
      o.res = {v.sign, 8'(e), 23'(q)};
    end
    return o;
  endfunction

  function automatic vec_t mk(logic s, int e, logic [47:0] m,
                              logic n, logic i, logic z);
    vec_t v;
    v.sign = s;
    v.exp  = 10'(e);
    v.mant = m;
    v.nan  = n;
    v.inf  = i;
    v.zero = z;
    return v;
  endfunction

  function automatic vec_t rand_vec();
    logic [23:0] a, b;
    int          k;
    a = 24'h800000 | 24'($urandom);
    b = 24'h800000 | 24'($urandom);
    k = $urandom_range(0, 31);
    return mk(1'($urandom), $urandom_range(0, 420) - 120,
              {24'd0, a} * {24'd0, b},
              k == 0, k >= 1 && k <= 3, k >= 3 && k <= 6);
  endfunction

  task automatic apply(vec_t v);
    in_sign = v.sign;
    in_exp  = v.exp;
    in_mant = v.mant;
    in_nan  = v.nan;
    in_inf  = v.inf;
    in_zero = v.zero;
  endtask

  task automatic chk(string name, logic [63:0] g, logic [63:0] w);
    checks++;
    if (g !== w) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, g, w);
    end
  endtask

  // Called at posedge+#1; returns at posedge+#1 after acceptance.
  task automatic drive(vec_t v);
    int n = 0;
    apply(v);
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("drive_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_empty", 64'(exp_q.size()), 0);
  endtask

  // Scoreboard: handshakes are decided at the next posedge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        got = {result, overflow, underflow, exception};
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_out: got %h want none", got);
        end else begin
          checks++;
          if (got !== exp_q[0]) begin
            errors++;
            $display("FAIL %s: got %h want %h",
                     out_ready ? "result" : "stall_hold",
                     got, exp_q[0]);
          end
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        cv = '{in_sign, in_exp, in_mant, in_nan, in_inf, in_zero};
        exp_q.push_back(model(cv));
        n_acc++;
      end
    end
  end

  vec_t dv[10];
  out_t dl[10];
  logic take;
  int   n0;

  initial begin
    dv[0] = mk(0, 128, 48'h600000000000, 0, 0, 0);
    dl[0] = {32'h40400000, 3'b000};
    dv[1] = mk(0, 127, 48'h400000400000, 0, 0, 0);
    dl[1] = {32'h3F800000, 3'b000};
    dv[2] = mk(0, 127, 48'h400000C00000, 0, 0, 0);
    dl[2] = {32'h3F800002, 3'b000};
    dv[3] = mk(0, 127, 48'h7FFFFFC00000, 0, 0, 0);
    dl[3] = {32'h40000000, 3'b000};
    dv[4] = mk(0, 254, 48'h800000000000, 0, 0, 0);
    dl[4] = {32'h7F800000, 3'b100};
    dv[5] = mk(1, 0, 48'h400000000000, 0, 0, 0);
    dl[5] = {32'h80000000, 3'b010};
    dv[6] = mk(0, 127, 48'h400000000000, 0, 1, 1);
    dl[6] = {32'h7FC00000, 3'b001};
    dv[7] = mk(1, 127, 48'h400000000000, 0, 1, 0);
    dl[7] = {32'hFF800000, 3'b000};
    dv[8] = mk(1, 127, 48'h400000000000, 1, 0, 0);
    dl[8] = {32'h7FC00000, 3'b001};
    dv[9] = mk(1, 200, 48'h400000000000, 0, 0, 1);
    dl[9] = {32'h80000000, 3'b000};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_result", 64'(result), 0);
    chk("rst_flags", 64'({overflow, underflow, exception}), 0);
    chk("rst_in_ready", 64'(in_ready), 1);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++)
      chk($sformatf("model_pin%0d", i), 64'(model(dv[i])), 64'(dl[i]));

    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) drive(dv[i]);
    drain();

    // Four back-to-back inputs against a 3-cycle stall.
    out_ready = 1'b0;
    n0 = n_acc;
    fork
      begin
        for (int i = 0; i < 4; i++) drive(rand_vec());
        in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("bp_accepts", 64'(n_acc - n0), 2);
        chk("bp_in_ready", 64'(in_ready), 0);
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_total", 64'(n_acc - n0), 4);

    // Fill the pipe, then reset while results are in flight.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apply(rand_vec());
      in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    chk("pre_rst_valid", 64'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 0);
    chk("mid_rst_result", 64'(result), 0);
    exp_q.delete();
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_valid", 64'(out_valid), 0);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      take = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (!in_valid || take) begin
        if ($urandom_range(0, 3) != 0) begin
          apply(rand_vec());
          in_valid = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = $urandom_range(0, 3) != 0;
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
